// File: rtl/mcycle_unit_param_if.sv
// Request/response bundle between the control unit and the multi-cycle mul/div unit.
interface mcycle_unit_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done, DivByZero
  );
endinterface

// File: rtl/mcycle_unit_param.sv
// Multi-cycle multiply/divide unit: shift-add multiply with early exit on the
// multiplier's highest set bit, restoring divide, divide-by-zero detection.
module mcycle_unit_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  mcycle_unit_param_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;

  logic                 start_prev_q;
  logic                 is_div_q;
  logic                 dz_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dvs_q;
  logic [WIDTH-1:0]     op1_q;
  logic [WIDTH-1:0]     res1_q;
  logic [WIDTH-1:0]     res2_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 launch;
  logic                 in_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       div_sh, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH-1:0]     fix_r1, fix_r2;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: multiply stops once the remaining multiplier bits are zero,
  // divide always runs WIDTH iterations, divide-by-zero skips RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = (bus.MCycleOp[1] && (bus.Operand2 == '0)) ? FIX : RUN;
      RUN: begin
        if (is_div_q) begin
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end else if (mplier_q[WIDTH-1:1] == '0) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Launch qualification, operand magnitudes, one divide step and sign fix-up.
  always_comb begin
    launch    = (state_q == IDLE) && bus.Start && !start_prev_q;
    in_signed = ~bus.MCycleOp[0];
    a_neg     = in_signed & bus.Operand1[WIDTH-1];
    b_neg     = in_signed & bus.Operand2[WIDTH-1];
    a_mag     = a_neg ? -bus.Operand1 : bus.Operand1;
    b_mag     = b_neg ? -bus.Operand2 : bus.Operand2;

    div_sh    = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, dvs_q};

    prod_fix  = neg_res_q ? -prod_q : prod_q;
    quo_fix   = neg_res_q ? -quo_q  : quo_q;
    rem_fix   = neg_rem_q ? -rem_q  : rem_q;

    if (!is_div_q) begin
      fix_r1 = prod_fix[WIDTH-1:0];
      fix_r2 = prod_fix[2*WIDTH-1:WIDTH];
    end else if (dz_q) begin
      fix_r1 = '1;
      fix_r2 = op1_q;
    end else begin
      fix_r1 = quo_fix;
      fix_r2 = rem_fix;
    end
  end

  // Outputs: Busy covers RUN and FIX, so it never overlaps the Done strobe.
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Result1   = res1_q;
  assign bus.Result2   = res2_q;

  // Datapath: latch at launch, iterate in RUN, commit results in FIX.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_prev_q <= 1'b0;
      is_div_q     <= 1'b0;
      dz_q         <= 1'b0;
      neg_res_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      cnt_q        <= '0;
      prod_q       <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      op1_q        <= '0;
      res1_q       <= '0;
      res2_q       <= '0;
      done_q       <= 1'b0;
      dbz_q        <= 1'b0;
    end else begin
      start_prev_q <= bus.Start;
      done_q       <= 1'b0;
      if (launch) begin
        is_div_q  <= bus.MCycleOp[1];
        dz_q      <= bus.MCycleOp[1] && (bus.Operand2 == '0);
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        cnt_q     <= '0;
        prod_q    <= '0;
        mcand_q   <= {{WIDTH{1'b0}}, a_mag};
        mplier_q  <= b_mag;
        rem_q     <= '0;
        quo_q     <= a_mag;
        dvs_q     <= b_mag;
        op1_q     <= bus.Operand1;
        dbz_q     <= 1'b0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            rem_q <= div_diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= div_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
      end else if (state_q == FIX) begin
        res1_q <= fix_r1;
        res2_q <= fix_r2;
        done_q <= 1'b1;
        dbz_q  <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit_param.sv
// Directed bench for mcycle_unit_param at WIDTH=32.
module tb_mcycle_unit_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mcycle_unit_param_if #(.WIDTH(32)) bus ();

  mcycle_unit_param #(.WIDTH(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.Start    = 1'b1;
  endtask

  // Steps until Done, counting Busy cycles on top of pre; bounded.
  task automatic wait_done(input int pre, output int busy_n);
    bit got;
    busy_n = pre;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (bus.Busy) busy_n++;
      if (bus.Busy && bus.Done) chk("busy_done_overlap", {62'd0, bus.Busy, bus.Done}, 64'd2);
      if (bus.Done) got = 1'b1;
    end
    chk("done_seen", {63'd0, got}, 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] r2, input logic [31:0] r1);
    chk(tag, {bus.Result2, bus.Result1}, {r2, r1});
  endtask

  task automatic drop_start();
    bus.Start = 1'b0;
    step();
  endtask

  initial begin
    int busy_n;

    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Done}, 64'd0);
    chk("rst_dbz", {63'd0, bus.DivByZero}, 64'd0);
    check_res("rst_res", 32'h0, 32'h0);
    rst = 1'b0;
    step();

    // 1: signed -1 x -1, Start held through Done and after
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, busy_n);
    chk("t1_busy", 64'(busy_n), 64'd2);
    check_res("t1_res", 32'h0000_0000, 32'h0000_0001);
    step();
    chk("t1_done_1cyc", {63'd0, bus.Done}, 64'd0);
    chk("t1_no_relaunch_a", {63'd0, bus.Busy}, 64'd0);
    step();
    step();
    chk("t1_no_relaunch_b", {63'd0, bus.Busy}, 64'd0);
    drop_start();

    // 2: unsigned full-width and short signed multiply
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, busy_n);
    chk("t2u_busy", 64'(busy_n), 64'd33);
    check_res("t2u_res", 32'hFFFF_FFFE, 32'h0000_0001);
    drop_start();
    start_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD);
    wait_done(0, busy_n);
    chk("t2s_busy", 64'(busy_n), 64'd3);
    check_res("t2s_res", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    drop_start();

    // 3: signed divide, including the overflow case
    start_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(0, busy_n);
    chk("t3a_busy", 64'(busy_n), 64'd33);
    check_res("t3a_res", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drop_start();
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, busy_n);
    check_res("t3b_res", 32'h0000_0000, 32'h8000_0000);
    chk("t3b_dbz", {63'd0, bus.DivByZero}, 64'd0);
    drop_start();

    // 4: divide by zero, flag held while idle, cleared at next launch
    start_op(2'b11, 32'h0000_0005, 32'h0000_0000);
    wait_done(0, busy_n);
    chk("t4z_busy", 64'(busy_n), 64'd1);
    check_res("t4z_res", 32'h0000_0005, 32'hFFFF_FFFF);
    chk("t4z_dbz", {63'd0, bus.DivByZero}, 64'd1);
    drop_start();
    step();
    chk("t4z_dbz_held", {63'd0, bus.DivByZero}, 64'd1);
    start_op(2'b11, 32'h0000_000A, 32'h0000_0003);
    step();
    chk("t4_dbz_clr", {63'd0, bus.DivByZero}, 64'd0);
    chk("t4_busy_at_launch", {63'd0, bus.Busy}, 64'd1);
    wait_done(1, busy_n);
    chk("t4_busy", 64'(busy_n), 64'd33);
    check_res("t4_res", 32'h0000_0001, 32'h0000_0003);
    drop_start();

    // 5: inputs change and Start pulses during the run
    start_op(2'b11, 32'd100, 32'd7);
    step();
    busy_n = bus.Busy ? 1 : 0;
    step();
    if (bus.Busy) busy_n++;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = 32'd3;
    bus.Operand2 = 32'd1;
    bus.Start    = 1'b0;
    step();
    if (bus.Busy) busy_n++;
    bus.Start = 1'b1;
    step();
    if (bus.Busy) busy_n++;
    bus.Start = 1'b0;
    wait_done(busy_n, busy_n);
    chk("t5_busy", 64'(busy_n), 64'd33);
    check_res("t5_res", 32'd2, 32'd14);
    step();
    step();
    step();
    chk("t5_no_second_op", {63'd0, bus.Busy}, 64'd0);

    // 6: reset on the 10th Busy cycle with Start held high
    start_op(2'b11, 32'h1234_5678, 32'h0000_0010);
    busy_n = 0;
    for (int i = 0; i < 20 && busy_n < 10; i++) begin
      step();
      if (bus.Busy) busy_n++;
    end
    chk("t6_reached_10", 64'(busy_n), 64'd10);
    rst = 1'b1;
    step();
    chk("t6_rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("t6_rst_done", {63'd0, bus.Done}, 64'd0);
    check_res("t6_rst_res", 32'h0, 32'h0);
    rst = 1'b0;
    step();
    chk("t6_relaunch", {63'd0, bus.Busy}, 64'd1);
    wait_done(bus.Busy ? 1 : 0, busy_n);
    chk("t6_busy", 64'(busy_n), 64'd33);
    check_res("t6_res", 32'h0000_0008, 32'h0123_4567);
    drop_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_unit_param.md
Name: mcycle_unit_param

Overview:
Parametrised multi-cycle multiply/divide unit for the ARMv3 datapath. It is the WIDTH-generic successor to the fixed 32-bit MCycle unit. It adds:
- early termination for multiplies
- divide-by-zero detection
- a one-cycle Done strobe
- rising-edge Start qualification, so a held Start cannot re-trigger an operation.

It sits beside the ALU. The control unit stalls the pipeline while Busy is high.

Parameters:
WIDTH, 32, operand and result width in bits (legal values 4..64).

Ports:
CLK  in  1  clock, rising-edge.
RESET  in  1  synchronous, active-high reset.
Start  in  1  operation request; an operation launches only on a sampled 0->1 transition.
MCycleOp  in  2  operation select: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
Operand1  in  WIDTH  multiplicand / dividend.
Operand2  in  WIDTH  multiplier / divisor.
Result1  out  WIDTH  mul: product low half; div: quotient.
Result2  out  WIDTH  mul: product high half; div: remainder.
Busy  out  1  high while an operation is in flight.
Done  out  1  one-cycle strobe; results valid from this cycle.
DivByZero  out  1  set with Done when the divisor is 0; held until the next launch.

Behaviour:
- Reset (synchronous, checked on the CLK edge):
  - state = IDLE.
  - Result1 = 0, Result2 = 0, Busy = 0, Done = 0, DivByZero = 0.
  - Start history register = 0.
  - RESET mid-operation aborts the operation; it has priority over everything else.
- Launch: at an edge in IDLE where Start = 1 and the previous sampled Start = 0, the unit latches Operand1, Operand2 and MCycleOp.
  - Input changes during the operation are ignored.
  - Start edges while not IDLE are ignored.
  - Start held high since reset release counts as a rising edge on the first sampled cycle.
- States: IDLE -> RUN -> FIX -> IDLE.
  - Launch edge: IDLE -> RUN, Busy = 1. A divide with divisor 0 goes IDLE -> FIX instead.
  - RUN: one radix-2 iteration per edge for N edges, then -> FIX.
  - FIX edge: write Result1/Result2, Done = 1 for exactly one cycle, Busy = 0, -> IDLE.
  - Busy is high for N+1 cycles (1 cycle on divide-by-zero).
  - Done and Busy are never high together.
- Signed ops: the launch edge converts operands to magnitudes (WIDTH-bit unsigned, so |-2^(WIDTH-1)| fits). FIX applies the signs.
- Multiply: shift-add on magnitudes, full 2*WIDTH-bit product.
  - N = max(1, position of the highest set bit of |Operand2| + 1).
  - This early termination is the fast path; N = WIDTH worst case.
  - Product is negated if the operand signs differ.
  - {Result2, Result1} is the exact 2*WIDTH-bit result.
- Divide: restoring division on magnitudes, N = WIDTH always.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Signed -2^(WIDTH-1) / -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0. No flag is raised.
- Divide by zero (both divide ops):
  - Result1 = all ones.
  - Result2 = Operand1 unchanged.
  - DivByZero = 1.
- Result1/Result2 hold their values until the next FIX edge or RESET. DivByZero clears at the next launch.

Test Plan:
1. WIDTH=32, op 00, FFFFFFFF x FFFFFFFF, Start held until Done -> {R2,R1} = 00000000_00000001; N = 1, Busy 2 cycles, Done 1 cycle; no re-launch while Start stays high.
2. op 01, FFFFFFFF x FFFFFFFF -> FFFFFFFE_00000001; Busy 33 cycles. Then op 00, 00000007 x FFFFFFFD -> FFFFFFFF_FFFFFFEB; Busy 3 cycles.
3. op 10, FFFFFFF9 / 00000002 -> R1 = FFFFFFFD, R2 = FFFFFFFF; Busy 33. Then 80000000 / FFFFFFFF -> R1 = 80000000, R2 = 00000000, DivByZero = 0.
4. op 11, 00000005 / 00000000 -> R1 = FFFFFFFF, R2 = 00000005, DivByZero = 1; Busy 1 cycle. Next launch of 0000000A / 00000003 -> R1 = 00000003, R2 = 00000001, DivByZero cleared at launch.
5. op 11 launch, change Operand1/Operand2/MCycleOp and pulse Start mid-run -> result matches the latched operands; no second operation starts.
6. op 11 launch, RESET on the 10th Busy cycle with Start held high -> next edge: Busy = 0, Done = 0, Results = 0. After RESET drops, the held Start launches a new op that completes normally.
